// File: rtl/multicycle_ctrl_unit.sv
`default_nettype none
// ============================================================================
// multicycle_ctrl_unit : multicycle RV32I-subset control FSM driving extended_ALU
// Build option TRAP_ON_ERROR_EN : ALU error flag in EXECUTE forces TRAP.  Rev 1.0
// ============================================================================
module multicycle_ctrl_unit #(
    parameter int RETIRE_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         instr,
    input  logic                mem_ready,
    input  logic                flagZ,
    input  logic                flagNegativo,
    input  logic                flagError,
    output logic                srcA_SEL,
    output logic                srcB_SEL,
    output logic [3:0]          SEL_OP,
    output logic                ir_write,
    output logic                tgt_write,
    output logic                pc_write,
    output logic                pc_src,
    output logic                reg_write,
    output logic                wb_sel,
    output logic                mem_read,
    output logic                mem_write,
    output logic                trap,
    output logic [RETIRE_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_TRAP      = 3'd5
    } state_t;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;

    localparam logic [31:0]         IR_RESET = 32'h0000_0013;
    localparam logic [RETIRE_W-1:0] RET_ONE  = {{(RETIRE_W-1){1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [31:0]         ir_q;
    logic [RETIRE_W-1:0] retired_q;
    logic                retire;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       alt;
    logic       is_r, is_i, is_load, is_store, is_branch, is_valid;
    logic       br_ok, br_taken, alu_fault;
    logic [3:0] alu_op;
    logic       unused_bits;

    assign opcode    = ir_q[6:0];
    assign funct3    = ir_q[14:12];
    assign alt       = ir_q[30];
    assign is_r      = (opcode == OPC_R);
    assign is_i      = (opcode == OPC_I);
    assign is_load   = (opcode == OPC_LOAD);
    assign is_store  = (opcode == OPC_STORE);
    assign is_branch = (opcode == OPC_BRANCH);
    assign is_valid  = is_r | is_i | is_load | is_store | is_branch;

`ifdef TRAP_ON_ERROR_EN
    assign alu_fault   = flagError;
    assign unused_bits = ^{ir_q[31], ir_q[29:15], ir_q[11:7]};
`else
    assign alu_fault   = 1'b0;
    assign unused_bits = ^{flagError, ir_q[31], ir_q[29:15], ir_q[11:7]};
`endif

    // Bit 30 selects SUB only for register ops; for I-type it is immediate data except SRAI.
    always_comb begin
        alu_op = OP_ADD;
        case (funct3)
            3'b000:  alu_op = (is_r && alt) ? OP_SUB : OP_ADD;
            3'b001:  alu_op = OP_SLL;
            3'b010:  alu_op = OP_SLT;
            3'b011:  alu_op = OP_SLTU;
            3'b100:  alu_op = OP_XOR;
            3'b101:  alu_op = alt ? OP_SRA : OP_SRL;
            3'b110:  alu_op = OP_OR;
            default: alu_op = OP_AND;
        endcase
    end

    always_comb begin
        br_ok    = 1'b1;
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = flagZ;
            3'b001:  br_taken = ~flagZ;
            3'b100:  br_taken = flagNegativo;
            3'b101:  br_taken = ~flagNegativo;
            default: br_ok    = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        retire    = 1'b0;
        srcA_SEL  = 1'b0;
        srcB_SEL  = 1'b0;
        SEL_OP    = OP_ADD;
        ir_write  = 1'b0;
        tgt_write = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 1'b0;
        reg_write = 1'b0;
        wb_sel    = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                srcA_SEL  = 1'b1;
                srcB_SEL  = 1'b1;
                tgt_write = 1'b1;
                state_d   = is_valid ? S_EXECUTE : S_TRAP;
            end
            S_EXECUTE: begin
                if (is_r) begin
                    SEL_OP = alu_op;
                end else if (is_i) begin
                    srcB_SEL = 1'b1;
                    SEL_OP   = alu_op;
                end else if (is_load || is_store) begin
                    srcB_SEL = 1'b1;
                end else begin
                    SEL_OP = OP_SUB;
                end

                // A fault must suppress the branch PC update as well as later stages.
                if (alu_fault || (is_branch && !br_ok)) begin
                    state_d = S_TRAP;
                end else if (is_branch) begin
                    pc_write = br_taken;
                    pc_src   = br_taken;
                    retire   = 1'b1;
                    state_d  = S_FETCH;
                end else if (is_load || is_store) begin
                    state_d = S_MEMORY;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                mem_read  = is_load;
                mem_write = is_store;
                if (mem_ready) begin
                    retire  = is_store;
                    state_d = is_store ? S_FETCH : S_WRITEBACK;
                end
            end
            S_WRITEBACK: begin
                reg_write = 1'b1;
                wb_sel    = is_load;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        if (rst) begin
            ir_write  = 1'b0;
            tgt_write = 1'b0;
            pc_write  = 1'b0;
            pc_src    = 1'b0;
            reg_write = 1'b0;
            wb_sel    = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            ir_q      <= IR_RESET;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (ir_write) begin
                ir_q <= instr;
            end
            if (retire) begin
                retired_q <= retired_q + RET_ONE;
            end
        end
    end

    assign trap    = (state_q == S_TRAP);
    assign retired = retired_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl_unit.sv
`default_nettype none
// Self-checking bench for multicycle_ctrl_unit: directed vector table, corner
// sequences and random instructions against a trace-level reference model.
module tb_multicycle_ctrl_unit;

    localparam int RW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   instr = 32'h0;
    logic          mem_ready = 1'b0;
    logic          flagZ = 1'b0, flagNegativo = 1'b0, flagError = 1'b0;
    logic          srcA_SEL, srcB_SEL;
    logic [3:0]    SEL_OP;
    logic          ir_write, tgt_write, pc_write, pc_src, reg_write, wb_sel;
    logic          mem_read, mem_write, trap;
    logic [RW-1:0] retired;

    multicycle_ctrl_unit #(.RETIRE_W(RW)) dut (
        .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready),
        .flagZ(flagZ), .flagNegativo(flagNegativo), .flagError(flagError),
        .srcA_SEL(srcA_SEL), .srcB_SEL(srcB_SEL), .SEL_OP(SEL_OP),
        .ir_write(ir_write), .tgt_write(tgt_write), .pc_write(pc_write),
        .pc_src(pc_src), .reg_write(reg_write), .wb_sel(wb_sel),
        .mem_read(mem_read), .mem_write(mem_write), .trap(trap), .retired(retired)
    );

    always #5 clk = ~clk;

    // Strobe bits of the observed vector {srcA, srcB, SEL_OP, strobes[8:0]}
    localparam logic [8:0] IRW = 9'h100, TGW = 9'h080, PCW = 9'h040, PCS = 9'h020;
    localparam logic [8:0] RGW = 9'h010, WBS = 9'h008, MRD = 9'h004, MWR = 9'h002;
    localparam logic [8:0] TRP = 9'h001;

    localparam logic [6:0] OPC_R = 7'h33, OPC_I = 7'h13, OPC_L = 7'h03;
    localparam logic [6:0] OPC_S = 7'h23, OPC_B = 7'h63;

    typedef struct {
        logic        mr;
        logic        sel_chk;
        logic [14:0] v;
    } cyc_t;

    typedef struct {
        logic [31:0] ins;
        logic        z, n, e;
        int          fst, mst;
        int          exp_len;
        bit          exp_trap;
    } vec_t;

    cyc_t          tr[$];
    int            n_chk = 0;
    int            n_fail = 0;
    logic [RW-1:0] exp_ret = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, expv);
        end
    endtask

    function automatic logic [14:0] dut_vec();
        return {srcA_SEL, srcB_SEL, SEL_OP, ir_write, tgt_write, pc_write, pc_src,
                reg_write, wb_sel, mem_read, mem_write, trap};
    endfunction

    function automatic logic rbit();
        return logic'($urandom_range(0, 1));
    endfunction

    function automatic void push(input logic mr, input logic sc, input logic [14:0] v);
        cyc_t c;
        c.mr = mr; c.sel_chk = sc; c.v = v;
        tr.push_back(c);
    endfunction

    function automatic void push_trap();
        for (int i = 0; i < 3; i++) push(rbit(), 1'b0, {6'd0, TRP});
    endfunction

    // One observation cycle in a stalled FETCH of the following instruction.
    function automatic void push_tail();
        push(1'b0, 1'b0, {6'd0, MRD});
    endfunction

    function automatic logic [3:0] op_of(input logic [2:0] f3, input logic altop);
        logic [3:0] tbl [8];
        tbl = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
        return tbl[f3] + {3'b000, altop};
    endfunction

    // Expected per-cycle trace of one instruction; returns 1 if it retires.
    function automatic bit build(input logic [31:0] ins, input logic z, input logic n,
                                 input logic e, input int fst, input int mst);
        logic [6:0] opc;
        logic [2:0] f3;
        logic       b30, fault, taken, br_ok;
        logic [8:0] st;
        opc = ins[6:0]; f3 = ins[14:12]; b30 = ins[30];
`ifdef TRAP_ON_ERROR_EN
        fault = e;
`else
        fault = 1'b0;
`endif
        tr.delete();
        for (int i = 0; i < fst; i++) push(1'b0, 1'b0, {6'd0, MRD});
        push(1'b1, 1'b0, {6'd0, MRD | IRW | PCW});
        push(rbit(), 1'b1, {2'b11, 4'd0, TGW});
        if (!(opc == OPC_R || opc == OPC_I || opc == OPC_L || opc == OPC_S || opc == OPC_B)) begin
            push_trap();
            return 1'b0;
        end
        if (opc == OPC_B) begin
            br_ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd4 || f3 == 3'd5);
            taken = (f3 == 3'd0) ? z : (f3 == 3'd1) ? !z : (f3 == 3'd4) ? n : !n;
            st = (br_ok && !fault && taken) ? (PCW | PCS) : 9'd0;
            push(rbit(), 1'b1, {2'b00, 4'd1, st});
            if (!br_ok || fault) begin
                push_trap();
                return 1'b0;
            end
            push_tail();
            return 1'b1;
        end
        if (opc == OPC_R)      push(rbit(), 1'b1, {2'b00, op_of(f3, b30 && (f3 == 3'd0 || f3 == 3'd5)), 9'd0});
        else if (opc == OPC_I) push(rbit(), 1'b1, {2'b01, op_of(f3, b30 && f3 == 3'd5), 9'd0});
        else                   push(rbit(), 1'b1, {2'b01, 4'd0, 9'd0});
        if (fault) begin
            push_trap();
            return 1'b0;
        end
        if (opc == OPC_L || opc == OPC_S) begin
            st = (opc == OPC_L) ? MRD : MWR;
            for (int i = 0; i < mst; i++) push(1'b0, 1'b0, {6'd0, st});
            push(1'b1, 1'b0, {6'd0, st});
            if (opc == OPC_S) begin
                push_tail();
                return 1'b1;
            end
        end
        push(rbit(), 1'b0, {6'd0, RGW | ((opc == OPC_L) ? WBS : 9'd0)});
        push_tail();
        return 1'b1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; mem_ready = 1'b1; instr = 32'h002081B3;
        @(negedge clk);
        #2;
        chk("rst_strobes", {23'd0, dut_vec() & 15'h01FF}, 32'd0);
        chk("rst_retired", {16'd0, retired}, 32'd0);
        @(negedge clk);
        rst = 1'b0; mem_ready = 1'b0;
        #2;
        chk("fetch_after_rst", {17'd0, dut_vec() & 15'h01FF}, {23'd0, MRD});
        exp_ret = '0;
    endtask

    task automatic run(input logic [31:0] ins, input logic z, input logic n, input logic e,
                       input int fst, input int mst, output int dut_len, output bit done);
        logic [RW-1:0] r0;
        logic [14:0]   act, expv;
        done = build(ins, z, n, e, fst, mst);
        dut_len = -1;
        r0 = retired;
        flagZ = z; flagNegativo = n; flagError = e;
        foreach (tr[k]) begin
            @(negedge clk);
            instr = tr[k].v[8] ? ins : $urandom();
            mem_ready = tr[k].mr;
            #2;
            act = dut_vec();
            expv = tr[k].v;
            if (!tr[k].sel_chk) begin
                act[14:9] = '0;
                expv[14:9] = '0;
            end
            chk($sformatf("cycle%0d_ins%08h", k, ins), {17'd0, act}, {17'd0, expv});
            if (dut_len < 0 && (retired !== r0 || trap === 1'b1)) dut_len = k;
        end
        if (done) begin
            exp_ret = exp_ret + 1'b1;
            chk("retired", {16'd0, retired}, {16'd0, exp_ret});
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [14];
        int          len;
        bit          done;
        int          cls;
        logic [31:0] ins;
        logic [2:0]  brf [5];

        tbl[0]  = '{32'h002081B3, 0, 0, 0, 0, 0, 4, 0};  // ADD
`ifdef TRAP_ON_ERROR_EN
        tbl[1]  = '{32'h402081B3, 0, 0, 1, 0, 0, 3, 1};  // SUB with ALU error
`else
        tbl[1]  = '{32'h402081B3, 0, 0, 1, 0, 0, 4, 0};
`endif
        tbl[2]  = '{32'h00208463, 1, 0, 0, 0, 0, 3, 0};  // BEQ taken
        tbl[3]  = '{32'h00208463, 0, 0, 0, 0, 0, 3, 0};  // BEQ not taken
        tbl[4]  = '{32'h00209463, 0, 0, 0, 0, 0, 3, 0};  // BNE taken
        tbl[5]  = '{32'h0020C463, 0, 1, 0, 0, 0, 3, 0};  // BLT taken
        tbl[6]  = '{32'h0020D463, 0, 1, 0, 0, 0, 3, 0};  // BGE not taken
        tbl[7]  = '{32'h0020E463, 0, 0, 0, 0, 0, 3, 1};  // BLTU unsupported
        tbl[8]  = '{32'h0000A283, 0, 0, 0, 0, 3, 8, 0};  // LW, 3 memory stalls
        tbl[9]  = '{32'h0000A283, 0, 0, 0, 0, 0, 5, 0};  // LW
        tbl[10] = '{32'h0020A223, 0, 0, 0, 2, 0, 6, 0};  // SW, 2 fetch stalls
        tbl[11] = '{32'h00500093, 0, 0, 0, 0, 0, 4, 0};  // ADDI
        tbl[12] = '{32'h4030D093, 0, 0, 0, 0, 0, 4, 0};  // SRAI
        tbl[13] = '{32'h0000007F, 0, 0, 0, 0, 0, 2, 1};  // illegal opcode

        do_reset();
        for (int i = 0; i < 14; i++) begin
            run(tbl[i].ins, tbl[i].z, tbl[i].n, tbl[i].e, tbl[i].fst, tbl[i].mst, len, done);
            chk($sformatf("latency_vec%0d", i), len, tbl[i].exp_len);
            chk($sformatf("trap_vec%0d", i), {31'd0, trap}, {31'd0, tbl[i].exp_trap});
            if (tbl[i].exp_trap) do_reset();
        end

        // Reset asserted during WRITEBACK of an ADD: the register write must not appear.
        do_reset();
        @(negedge clk); instr = 32'h002081B3; mem_ready = 1'b1; flagError = 1'b0;
        @(negedge clk); mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        #2;
        chk("rst_mid_strobes", {23'd0, dut_vec() & 15'h01FF}, 32'd0);
        @(negedge clk); rst = 1'b0; mem_ready = 1'b0;
        #2;
        chk("rst_mid_retired", {16'd0, retired}, 32'd0);
        chk("rst_mid_fetch", {17'd0, dut_vec() & 15'h01FF}, {23'd0, MRD});
        exp_ret = '0;

        brf = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6};
        for (int t = 0; t < 300; t++) begin
            cls = $urandom_range(0, 15);
            ins = $urandom();
            if (cls < 4)       ins[6:0] = OPC_R;
            else if (cls < 7)  ins[6:0] = OPC_I;
            else if (cls < 9)  ins[6:0] = OPC_L;
            else if (cls < 11) ins[6:0] = OPC_S;
            else if (cls < 15) begin
                ins[6:0] = OPC_B;
                ins[14:12] = brf[$urandom_range(0, 4)];
            end else ins[6:0] = 7'h37;
            run(ins, rbit(), rbit(), ($urandom_range(0, 7) == 0),
                $urandom_range(0, 2), $urandom_range(0, 2), len, done);
            if (!done) begin
                chk("rand_trap", {31'd0, trap}, 32'd1);
                do_reset();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
